// File: rtl/mod_demod_gen_v3.sv
// rtl/mod_demod_gen_v3.sv - square-wave modulator with half-period synchronous demodulator
module mod_demod_gen_v3 #(
    parameter int ADC_W    = 14,
    parameter int OUT_W    = 32,
    parameter int AVG_LOG2 = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [31:0]             i_freq_cnt,
    input  logic [OUT_W-1:0]        i_amp_H,
    input  logic [OUT_W-1:0]        i_amp_L,
    input  logic [15:0]             i_wait_cnt,
    input  logic                    i_polarity,
    input  logic signed [OUT_W-1:0] i_err_offset,
    input  logic signed [ADC_W-1:0] i_adc_data,
    output logic [OUT_W-1:0]        o_mod_out,
    output logic                    o_status,
    output logic                    o_stepTrig,
    output logic signed [OUT_W-1:0] o_err,
    output logic                    o_sync,
    output logic                    o_short,
    output logic [1:0]              o_cstate
);

    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam int E_W   = OUT_W + 2;
    localparam logic [AVG_LOG2:0] ACC_LAST = (AVG_LOG2+1)'(2**AVG_LOG2 - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACC  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, next_state;

    logic [31:0]              period;
    logic [31:0]              cnt;
    logic [31:0]              freq_clamped;
    logic [15:0]              wcnt;
    logic [AVG_LOG2:0]        acnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  sum_h;
    logic                     h_valid;
    logic                     tag;
    logic signed [ACC_W:0]    diff;
    logic signed [ACC_W:0]    avg;
    logic signed [E_W-1:0]    avg_ext;
    logic signed [E_W-1:0]    err_full;
    logic [OUT_W-1:0]         err_sat;

    assign freq_clamped = (i_freq_cnt < 32'd2) ? 32'd2 : i_freq_cnt;
    assign o_cstate     = state;

    // Period is only picked up at boundaries so a half never changes length mid-flight
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            period     <= freq_clamped;
            cnt        <= 32'd0;
            o_status   <= 1'b0;
            o_stepTrig <= 1'b0;
            o_mod_out  <= '0;
        end else begin
            o_mod_out <= o_status ? i_amp_H : i_amp_L;
            if (cnt == period - 32'd1) begin
                cnt        <= 32'd0;
                o_status   <= ~o_status;
                o_stepTrig <= 1'b1;
                period     <= freq_clamped;
            end else begin
                cnt        <= cnt + 32'd1;
                o_stepTrig <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: next_state = S_IDLE;
            S_WAIT: if ({1'b0, wcnt} + 17'd1 >= {1'b0, i_wait_cnt}) next_state = S_ACC;
            S_ACC:  if (acnt == ACC_LAST) next_state = S_DONE;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        if (o_stepTrig) begin
            next_state = (i_wait_cnt == 16'd0) ? S_ACC : S_WAIT;
        end
    end

    // At DONE the accumulator itself holds the low-half sum, so the error is formed from it directly
    always_comb begin
        diff     = (ACC_W+1)'(sum_h) - (ACC_W+1)'(acc);
        avg      = diff >>> AVG_LOG2;
        avg_ext  = E_W'(avg);
        err_full = (i_polarity ? -avg_ext : avg_ext) + E_W'(i_err_offset);
        err_sat  = err_full[OUT_W-1:0];
        if (err_full[E_W-1:OUT_W-1] != {3{err_full[E_W-1]}}) begin
            err_sat = err_full[E_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wcnt    <= 16'd0;
            acnt    <= '0;
            acc     <= '0;
            sum_h   <= '0;
            h_valid <= 1'b0;
            tag     <= 1'b0;
            o_err   <= '0;
            o_sync  <= 1'b0;
            o_short <= 1'b0;
        end else begin
            o_sync <= 1'b0;
            case (state)
                S_WAIT: wcnt <= wcnt + 16'd1;
                S_ACC: begin
                    acc  <= acc + ACC_W'(i_adc_data);
                    acnt <= acnt + (AVG_LOG2+1)'(1);
                end
                S_DONE: begin
                    if (tag) begin
                        sum_h   <= acc;
                        h_valid <= 1'b1;
                    end else if (h_valid) begin
                        o_err   <= $signed(err_sat);
                        o_sync  <= 1'b1;
                        h_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (o_stepTrig) begin
                wcnt <= 16'd0;
                acnt <= '0;
                acc  <= '0;
                tag  <= o_status;
                if (state == S_WAIT || state == S_ACC) begin
                    o_short <= 1'b1;
                    h_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mod_demod_gen_v3.sv
// tb/tb_mod_demod_gen_v3.sv - table-driven and randomized bench for mod_demod_gen_v3
module tb_mod_demod_gen_v3;

    localparam int ADC_W    = 14;
    localparam int OUT_W    = 32;
    localparam int AVG_LOG2 = 2;
    localparam int N        = 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [31:0]             freq = 32'd10;
    logic [OUT_W-1:0]        amp_h = '0;
    logic [OUT_W-1:0]        amp_l = '0;
    logic [15:0]             wait_cnt = 16'd3;
    logic                    pol = 1'b0;
    logic signed [OUT_W-1:0] off = '0;
    logic signed [ADC_W-1:0] adc = '0;
    logic [OUT_W-1:0]        mod_out;
    logic                    status;
    logic                    step_trig;
    logic signed [OUT_W-1:0] err;
    logic                    sync;
    logic                    short_flag;
    logic [1:0]              cstate;

    mod_demod_gen_v3 #(.ADC_W(ADC_W), .OUT_W(OUT_W), .AVG_LOG2(AVG_LOG2)) dut (
        .i_clk(clk), .i_rst(rst), .i_freq_cnt(freq), .i_amp_H(amp_h), .i_amp_L(amp_l),
        .i_wait_cnt(wait_cnt), .i_polarity(pol), .i_err_offset(off), .i_adc_data(adc),
        .o_mod_out(mod_out), .o_status(status), .o_stepTrig(step_trig), .o_err(err),
        .o_sync(sync), .o_short(short_flag), .o_cstate(cstate)
    );

    always #5 clk = ~clk;

    typedef struct {
        string  name;
        int     freq;
        int     wt;
        bit     pol;
        int     off;
        int     hi;
        int     lo;
        bit     rnd;
        longint err_final;
    } vec_t;

    int     nerr = 0;
    int     nchk = 0;
    int     cfg_p, cfg_w, cfg_hi, cfg_lo;
    bit     cfg_rnd;
    longint exp_err;
    int     hist [0:1023];
    vec_t   vecs [$];

    task automatic chk(input string nm, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input int f, input int w, input bit p,
                                input int o, input int hi, input int lo, input bit r,
                                input longint e);
        vec_t v;
        v.name = nm; v.freq = f; v.wt = w; v.pol = p; v.off = o;
        v.hi = hi; v.lo = lo; v.rnd = r; v.err_final = e;
        return v;
    endfunction

    // Reference: floor-average of the difference, optional negation, offset, signed 32-bit clamp
    function automatic longint model_err(input longint sh, input longint sl, input bit p, input longint o);
        longint d, a;
        d = sh - sl;
        a = (d >= 0) ? d / N : -((-d + N - 1) / N);
        if (p) a = -a;
        a = a + o;
        if (a > 64'sd2147483647) a = 64'sd2147483647;
        if (a < -64'sd2147483648) a = -64'sd2147483648;
        return a;
    endfunction

    function automatic longint half_sum(input int h);
        longint s = 0;
        for (int i = 1; i <= N; i++) s += hist[h*cfg_p + cfg_w + i];
        return s;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_mod_out", longint'(mod_out), 0);
            chk("rst_status", longint'(status), 0);
            chk("rst_step", longint'(step_trig), 0);
            chk("rst_err", longint'(err), 0);
            chk("rst_sync", longint'(sync), 0);
            chk("rst_short", longint'(short_flag), 0);
            chk("rst_cstate", longint'(cstate), 0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        exp_err = 0;
    endtask

    // Cycle k = k clocks after the last reset edge; half h spans [h*P, (h+1)*P)
    task automatic run_cycles(input int n);
        bit is_short;
        is_short = (cfg_w + N >= cfg_p);
        for (int k = 0; k < n; k++) begin
            int v, r, m, h, est;
            bit esync;
            if (cfg_rnd) v = int'($urandom_range(0, 16383)) - 8192;
            else         v = ((k / cfg_p) % 2 == 1) ? cfg_hi : cfg_lo;
            hist[k] = v;
            adc = v[ADC_W-1:0];
            @(negedge clk);
            chk("status", longint'(status), (k / cfg_p) % 2);
            chk("step_trig", longint'(step_trig), (k >= cfg_p && k % cfg_p == 0) ? 1 : 0);
            if (k == 0) chk("mod_out", longint'(mod_out), 0);
            else chk("mod_out", longint'(mod_out), ((k - 1) / cfg_p) % 2 == 1 ? longint'(amp_h) : longint'(amp_l));
            chk("short", longint'(short_flag), (is_short && k >= 2*cfg_p + 1) ? 1 : 0);
            if (!is_short) begin
                r = (k % cfg_p == 0) ? cfg_p : k % cfg_p;
                if (k <= cfg_p)               est = 0;
                else if (r <= cfg_w)          est = 1;
                else if (r <= cfg_w + N)      est = 2;
                else if (r == cfg_w + N + 1)  est = 3;
                else                          est = 0;
                chk("cstate", longint'(cstate), est);
            end
            esync = 1'b0;
            m = k - (cfg_w + N + 2);
            if (!is_short && m >= 0 && m % cfg_p == 0) begin
                h = m / cfg_p;
                if (h >= 2 && h % 2 == 0) begin
                    esync = 1'b1;
                    exp_err = model_err(half_sum(h - 1), half_sum(h), pol, longint'(off));
                end
            end
            chk("sync", longint'(sync), esync);
            chk("err", longint'(err), exp_err);
            @(posedge clk); #1;
        end
    endtask

    task automatic configure(input vec_t v);
        freq     = v.freq;
        wait_cnt = v.wt[15:0];
        pol      = v.pol;
        off      = v.off;
        cfg_p    = (v.freq < 2) ? 2 : v.freq;
        cfg_w    = v.wt;
        cfg_hi   = v.hi;
        cfg_lo   = v.lo;
        cfg_rnd  = v.rnd;
        amp_h    = $urandom;
        amp_l    = $urandom;
    endtask

    initial begin
        int trig [$];
        int exp_trig [4];
        vec_t v;

        vecs.push_back(mk("basic",    10, 3, 0, 0,            1000,  200,  0, 800));
        vecs.push_back(mk("pol_off",  10, 3, 1, 5,            1000,  200,  0, -795));
        vecs.push_back(mk("sat_pos",  10, 3, 0, 32'h7FFFFFF0, 1000,  200,  0, 64'sd2147483647));
        vecs.push_back(mk("short",     5, 3, 0, 0,            1000,  200,  0, 0));
        vecs.push_back(mk("nowait",   10, 0, 0, 0,            -300,  500,  0, -800));
        vecs.push_back(mk("clamp",     1, 0, 0, 0,            1000,  200,  0, 0));
        vecs.push_back(mk("extremes",  7, 2, 0, -10,         -8192, 8191,  0, -16393));
        vecs.push_back(mk("sat_neg",  10, 3, 1, 32'h80000005, 1000,  200,  0, -64'sd2147483648));
        vecs.push_back(mk("tight",     8, 3, 0, 0,              50,  -70,  0, 120));
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mk("random", int'($urandom_range(8, 20)), int'($urandom_range(0, 3)),
                              1'($urandom_range(0, 1)), int'($urandom_range(0, 2000)) - 1000,
                              0, 0, 1, 0));
        end

        foreach (vecs[i]) begin
            configure(vecs[i]);
            apply_reset();
            run_cycles(6*cfg_p + cfg_w + N + 4);
            if (!vecs[i].rnd) chk({"final_err_", vecs[i].name}, longint'(err), vecs[i].err_final);
        end

        // Period change mid-half: the running half keeps its length, later halves take the new one
        v = mk("period_chg", 10, 3, 0, 0, 0, 0, 0, 0);
        configure(v);
        apply_reset();
        adc = '0;
        for (int k = 0; k < 70; k++) begin
            if (k == 13) freq = 32'd20;
            @(negedge clk);
            if (step_trig) trig.push_back(k);
            @(posedge clk); #1;
        end
        exp_trig = '{10, 20, 40, 60};
        chk("trig_count", trig.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < trig.size()) chk("trig_pos", trig[i], exp_trig[i]);
        end

        // Reset in the middle of a high-half accumulation
        v = mk("rst_mid", 10, 3, 0, 0, 1000, 200, 0, 800);
        configure(v);
        apply_reset();
        run_cycles(35);
        chk("pre_rst_cstate", longint'(cstate), 2);
        chk("pre_rst_err", longint'(err), 800);
        apply_reset();
        cfg_hi = 2000;
        run_cycles(40);
        chk("post_rst_err", longint'(err), 1800);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mod_demod_gen_v3.md
MOD_DEMOD_GEN_V3 -- requirements
Module: mod_demod_gen_v3

Interface
REQ-001 SHALL have parameter ADC_W, default 14: ADC sample width, signed.
REQ-002 SHALL have parameter OUT_W, default 32: width of modulation amplitudes, error and offset.
REQ-003 SHALL have parameter AVG_LOG2, default 3: log2 of samples averaged per half-period.
REQ-004 SHALL have port i_clk, input, 1: single clock, all logic rising-edge.
REQ-005 SHALL have port i_rst, input, 1: synchronous reset, active-high.
REQ-006 SHALL have port i_freq_cnt, input, 32: half-period length in clocks.
REQ-007 SHALL have ports i_amp_H and i_amp_L, input, OUT_W: high and low modulation levels.
REQ-008 SHALL have port i_wait_cnt, input, 16: settle clocks skipped after each half boundary.
REQ-009 SHALL have port i_polarity, input, 1: 1 = negate error.
REQ-010 SHALL have port i_err_offset, input, OUT_W signed: added to error.
REQ-011 SHALL have port i_adc_data, input, ADC_W signed: demodulator sample, one per clock.
REQ-012 SHALL have port o_mod_out, output, OUT_W: modulation output.
REQ-013 SHALL have port o_status, output, 1: 1 = high half.
REQ-014 SHALL have port o_stepTrig, output, 1: one-cycle pulse on the first cycle of each half.
REQ-015 SHALL have port o_err, output, OUT_W signed: demodulated error.
REQ-016 SHALL have port o_sync, output, 1: one-cycle pulse when o_err updates.
REQ-017 SHALL have port o_short, output, 1: sticky flag, half-period too short to finish averaging.
REQ-018 SHALL have port o_cstate, output, 2: demodulator state (IDLE=0, WAIT=1, ACC=2, DONE=3).

Function
REQ-019 SHALL latch i_freq_cnt into an internal period register only at reset release and at each half boundary; values below 2 SHALL be treated as 2.
REQ-020 SHALL run a half-period counter 0..period-1; on reaching period-1 it SHALL wrap to 0, toggle o_status and assert o_stepTrig in the following cycle.
REQ-021 SHALL register o_mod_out every cycle as i_amp_H when o_status=1, else i_amp_L; amplitude changes SHALL take effect one cycle later.
REQ-022 SHALL hold the demodulator in IDLE after reset until the first o_stepTrig.
REQ-023 SHALL, on o_stepTrig in any state, clear the accumulator, capture o_status as the half tag and enter WAIT, or ACC directly if i_wait_cnt=0.
REQ-024 SHALL stay in WAIT for exactly i_wait_cnt cycles, then enter ACC.
REQ-025 SHALL, in ACC, add sign-extended i_adc_data to an ADC_W+AVG_LOG2-bit accumulator for exactly 2^AVG_LOG2 cycles, then enter DONE.
REQ-026 SHALL, in DONE, store the sum as sum_H (tag=1, with a valid bit set) or sum_L (tag=0), then go to IDLE.
REQ-027 SHALL, if o_stepTrig arrives while in WAIT or ACC, set o_short, clear the sum_H valid bit and restart per REQ-023.
REQ-028 SHALL compute the error only on a low-half DONE with sum_H valid: avg = (sum_H - sum_L) arithmetically shifted right by AVG_LOG2.
REQ-029 SHALL then sign-extend avg to OUT_W, negate it if i_polarity=1, add i_err_offset and saturate to the signed OUT_W range.
REQ-030 SHALL clear the sum_H valid bit after each error computation.
REQ-031 SHALL make o_err and the o_sync pulse appear 2 cycles after the cycle the last sample is accumulated; o_err SHALL hold between updates.
REQ-032 SHALL sample i_polarity and i_err_offset at the DONE cycle.

Reset
REQ-033 SHALL, while i_rst=1, drive o_mod_out=0, o_status=0, o_stepTrig=0, o_err=0, o_sync=0, o_short=0 and o_cstate=IDLE, and SHALL clear the counter, accumulator, sums and valid bit.
REQ-034 SHALL, on reset asserted mid-operation, discard partial sums; the first error after release SHALL require a complete new high/low pair.

Verification (ADC_W=14, OUT_W=32, AVG_LOG2=2, i_freq_cnt=10, i_wait_cnt=3 unless stated)
REQ-035 SHALL cover the basic pair: adc=1000 in the high half and 200 in the low half -> o_err=800, o_sync once per full period, o_stepTrig every 10 clocks.
REQ-036 SHALL cover polarity and offset: same stimulus with i_polarity=1 and i_err_offset=5 -> o_err=-795.
REQ-037 SHALL cover saturation: i_err_offset=0x7FFFFFF0 with the REQ-035 stimulus -> o_err=0x7FFFFFFF.
REQ-038 SHALL cover a short half: i_freq_cnt=5 with i_wait_cnt=3 -> o_short=1 and stays set, no o_sync.
REQ-039 SHALL cover a period change: i_freq_cnt changed 10->20 mid-half -> the current half completes at 10 and later halves last 20.
REQ-040 SHALL cover reset mid-ACC: o_err=0 during reset, no o_sync until a full high+low pair completes after release.
